// File: rtl/sc1_cpu_core.sv
// sc1_cpu_core: multi-cycle processor with a 16 x WIDTH_REG register file and an internal data RAM.
// Optional macro SC1_MUL_EN adds opcode 0x13 MUL; when undefined, 0x13 executes as a NOP.
module sc1_cpu_core #(
    parameter int unsigned WIDTH_D   = 32,
    parameter int unsigned WIDTH_REG = 32,
    parameter int unsigned DEPTH_I   = 8,
    parameter int unsigned DEPTH_D   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [DEPTH_I-1:0]   rom_addr,
    input  logic [31:0]          rom_data,
    input  logic [WIDTH_REG-1:0] port_in,
    output logic [WIDTH_REG-1:0] port_out
);

    localparam logic [7:0] OP_LDI  = 8'h01;
    localparam logic [7:0] OP_LDIH = 8'h02;
    localparam logic [7:0] OP_ADD  = 8'h03;
    localparam logic [7:0] OP_SUB  = 8'h04;
    localparam logic [7:0] OP_AND  = 8'h05;
    localparam logic [7:0] OP_OR   = 8'h06;
    localparam logic [7:0] OP_XOR  = 8'h07;
    localparam logic [7:0] OP_SHL  = 8'h08;
    localparam logic [7:0] OP_SHR  = 8'h09;
    localparam logic [7:0] OP_ADDI = 8'h0A;
    localparam logic [7:0] OP_LD   = 8'h0B;
    localparam logic [7:0] OP_ST   = 8'h0C;
    localparam logic [7:0] OP_IN   = 8'h0D;
    localparam logic [7:0] OP_OUT  = 8'h0E;
    localparam logic [7:0] OP_JMP  = 8'h0F;
    localparam logic [7:0] OP_BEZ  = 8'h10;
    localparam logic [7:0] OP_BNZ  = 8'h11;
    localparam logic [7:0] OP_HALT = 8'h12;
`ifdef SC1_MUL_EN
    localparam logic [7:0] OP_MUL  = 8'h13;
`endif

    typedef enum logic [1:0] {
        StFetch,
        StExec,
        StMem
    } state_e;

    state_e               r_state;
    logic [DEPTH_I-1:0]   r_pc;
    logic [WIDTH_REG-1:0] r_regs [16];
    logic [WIDTH_REG-1:0] r_port_out;
    logic                 r_halted;
    logic [3:0]           r_ld_rd;
    logic [WIDTH_D-1:0]   r_ram [2**DEPTH_D];
    logic [WIDTH_D-1:0]   r_ram_rdata;

    logic [7:0]           w_op;
    logic [3:0]           w_rd;
    logic [3:0]           w_ra;
    logic [3:0]           w_rb;
    logic [15:0]          w_imm;
    logic [WIDTH_REG-1:0] w_rd_val;
    logic [WIDTH_REG-1:0] w_ra_val;
    logic [WIDTH_REG-1:0] w_rb_val;
    logic [WIDTH_REG-1:0] w_sext;
    logic [DEPTH_D-1:0]   w_ram_addr;
    logic [WIDTH_REG-1:0] w_alu;
    logic                 w_alu_we;
    logic                 w_jump;
    logic                 w_is_ld;
    logic                 w_is_st;
    logic                 w_is_out;
    logic                 w_is_halt;
    logic                 w_exec;
    logic                 w_ram_we;
    logic [DEPTH_I-1:0]   w_pc_next;

    assign rom_addr = r_pc;
    assign port_out = r_port_out;

    assign w_op     = rom_data[31:24];
    assign w_rd     = rom_data[23:20];
    assign w_ra     = rom_data[19:16];
    assign w_rb     = rom_data[15:12];
    assign w_imm    = rom_data[15:0];
    assign w_rd_val = r_regs[w_rd];
    assign w_ra_val = r_regs[w_ra];
    assign w_rb_val = r_regs[w_rb];
    assign w_sext   = WIDTH_REG'($signed(w_imm));

    assign w_ram_addr = DEPTH_D'(w_ra_val + w_sext);
    assign w_exec     = (r_state == StExec) && !r_halted;
    // Gating with reset keeps an aborted ST from reaching the RAM.
    assign w_ram_we   = reset && w_exec && w_is_st;
    assign w_pc_next  = w_jump ? DEPTH_I'(w_imm) : r_pc + DEPTH_I'(1);

    always_comb begin
        w_alu     = '0;
        w_alu_we  = 1'b0;
        w_jump    = 1'b0;
        w_is_ld   = 1'b0;
        w_is_st   = 1'b0;
        w_is_out  = 1'b0;
        w_is_halt = 1'b0;
        case (w_op)
            OP_LDI:  begin w_alu = w_sext;               w_alu_we = 1'b1; end
            OP_LDIH: begin
                w_alu    = (WIDTH_REG'(w_imm) << 16) | WIDTH_REG'(w_rd_val[15:0]);
                w_alu_we = 1'b1;
            end
            OP_ADD:  begin w_alu = w_ra_val + w_rb_val;  w_alu_we = 1'b1; end
            OP_SUB:  begin w_alu = w_ra_val - w_rb_val;  w_alu_we = 1'b1; end
            OP_AND:  begin w_alu = w_ra_val & w_rb_val;  w_alu_we = 1'b1; end
            OP_OR:   begin w_alu = w_ra_val | w_rb_val;  w_alu_we = 1'b1; end
            OP_XOR:  begin w_alu = w_ra_val ^ w_rb_val;  w_alu_we = 1'b1; end
            OP_SHL:  begin w_alu = w_ra_val << w_rb_val[4:0]; w_alu_we = 1'b1; end
            OP_SHR:  begin w_alu = w_ra_val >> w_rb_val[4:0]; w_alu_we = 1'b1; end
            OP_ADDI: begin w_alu = w_ra_val + w_sext;    w_alu_we = 1'b1; end
            OP_LD:   w_is_ld = 1'b1;
            OP_ST:   w_is_st = 1'b1;
            OP_IN:   begin w_alu = port_in;              w_alu_we = 1'b1; end
            OP_OUT:  w_is_out = 1'b1;
            OP_JMP:  w_jump = 1'b1;
            OP_BEZ:  w_jump = (w_rd_val == '0);
            OP_BNZ:  w_jump = (w_rd_val != '0);
            OP_HALT: w_is_halt = 1'b1;
`ifdef SC1_MUL_EN
            OP_MUL:  begin w_alu = w_ra_val * w_rb_val;  w_alu_we = 1'b1; end
`endif
            default: ;
        endcase
    end

    // Single-port RAM, no reset; read data is consumed in MEM after an LD.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_ram_addr] <= WIDTH_D'(w_rd_val);
        end
        r_ram_rdata <= r_ram[w_ram_addr];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= StFetch;
            r_pc       <= '0;
            r_port_out <= '0;
            r_halted   <= 1'b0;
            r_ld_rd    <= '0;
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                StFetch: r_state <= StExec;
                StExec: begin
                    r_state <= StFetch;
                    if (!r_halted) begin
                        if (w_is_halt) begin
                            r_halted <= 1'b1;
                        end else begin
                            r_pc <= w_pc_next;
                            if (w_alu_we) begin
                                r_regs[w_rd] <= w_alu;
                            end
                            if (w_is_out) begin
                                r_port_out <= w_rd_val;
                            end
                            if (w_is_ld) begin
                                r_state <= StMem;
                                r_ld_rd <= w_rd;
                            end
                        end
                    end
                end
                StMem: begin
                    r_regs[r_ld_rd] <= WIDTH_REG'(r_ram_rdata);
                    r_state         <= StFetch;
                end
                default: r_state <= StFetch;
            endcase
        end
    end

endmodule

// File: tb/tb_sc1_cpu_core.sv
// Bench for sc1_cpu_core: runs small programs from a modelled ROM and scoreboards port_out.
module tb_sc1_cpu_core;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LDI  = 8'h01;
    localparam logic [7:0] OP_LDIH = 8'h02;
    localparam logic [7:0] OP_ADD  = 8'h03;
    localparam logic [7:0] OP_SUB  = 8'h04;
    localparam logic [7:0] OP_AND  = 8'h05;
    localparam logic [7:0] OP_OR   = 8'h06;
    localparam logic [7:0] OP_XOR  = 8'h07;
    localparam logic [7:0] OP_SHL  = 8'h08;
    localparam logic [7:0] OP_SHR  = 8'h09;
    localparam logic [7:0] OP_ADDI = 8'h0A;
    localparam logic [7:0] OP_LD   = 8'h0B;
    localparam logic [7:0] OP_ST   = 8'h0C;
    localparam logic [7:0] OP_IN   = 8'h0D;
    localparam logic [7:0] OP_OUT  = 8'h0E;
    localparam logic [7:0] OP_JMP  = 8'h0F;
    localparam logic [7:0] OP_BEZ  = 8'h10;
    localparam logic [7:0] OP_HALT = 8'h12;
    localparam logic [7:0] OP_X13  = 8'h13;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic [31:0] port_in = '0;
    logic [31:0] port_out;

    logic [31:0] rom [256];
    logic [31:0] sb [$];
    int          cyc = 0;
    int          c0 = 0;
    int          n_chk = 0;
    int          n_err = 0;

    sc1_cpu_core dut (
        .clk      (clk),
        .reset    (reset),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .port_in  (port_in),
        .port_out (port_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= rom[rom_addr];

    function automatic logic [31:0] enc_r(input logic [7:0] op, input logic [3:0] rd,
                                          input logic [3:0] ra, input logic [3:0] rb);
        return {op, rd, ra, rb, 12'h000};
    endfunction

    function automatic logic [31:0] enc_i(input logic [7:0] op, input logic [3:0] rd,
                                          input logic [3:0] ra, input logic [15:0] imm);
        return {op, rd, ra, imm};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = {OP_NOP, 24'h0};
    endtask

    task automatic hold_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset();
        reset = 1'b1;
        c0 = cyc;
    endtask

    // Waits for port_out to change; delta is cycles since reset release.
    task automatic wait_change(input int budget, output bit timed_out, output int delta);
        logic [31:0] prev;
        int n;
        prev = port_out;
        timed_out = 1'b1;
        n = 0;
        while (timed_out && n < budget) begin
            @(negedge clk);
            n++;
            if (port_out !== prev) timed_out = 1'b0;
        end
        delta = cyc - c0;
    endtask

    task automatic test_reset();
        clear_rom();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_chk++;
            if (rom_addr !== 8'd0) begin
                n_err++;
                $display("FAIL reset_rom_addr: got %h expected 00", rom_addr);
            end
            n_chk++;
            if (port_out !== 32'd0) begin
                n_err++;
                $display("FAIL reset_port_out: got %h expected 00000000", port_out);
            end
        end
        release_reset();
        n_chk++;
        if (rom_addr !== 8'd0) begin
            n_err++;
            $display("FAIL reset_first_fetch: got %h expected 00", rom_addr);
        end
        repeat (2) @(negedge clk);
        n_chk++;
        if (rom_addr !== 8'd1) begin
            n_err++;
            $display("FAIL reset_nop_2cyc: got %h expected 01", rom_addr);
        end
    endtask

    task automatic test_counter();
        logic [31:0] exp;
        bit to;
        int d, last, want;
        hold_reset();
        clear_rom();
        rom[0] = enc_i(OP_LDI, 4'd1, 4'd0, 16'd0);
        rom[1] = enc_i(OP_LDI, 4'd2, 4'd0, 16'd1);
        rom[2] = enc_r(OP_ADD, 4'd1, 4'd1, 4'd2);
        rom[3] = enc_r(OP_OUT, 4'd1, 4'd0, 4'd0);
        rom[4] = enc_i(OP_JMP, 4'd0, 4'd0, 16'd2);
        for (int k = 1; k <= 5; k++) sb.push_back(32'(k));
        release_reset();
        last = 0;
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            wait_change(20, to, d);
            want = (last == 0) ? 8 : last + 6;
            n_chk++;
            if (to || port_out !== exp) begin
                n_err++;
                $display("FAIL counter_value: got %h expected %h", port_out, exp);
            end
            n_chk++;
            if (d != want) begin
                n_err++;
                $display("FAIL counter_timing: got cycle %0d expected %0d", d, want);
            end
            last = d;
        end
    endtask

    task automatic test_mem();
        logic [31:0] exp;
        bit to;
        int d;
        hold_reset();
        clear_rom();
        rom[0] = enc_i(OP_LDI, 4'd3, 4'd0, 16'h1234);
        rom[1] = enc_i(OP_ST,  4'd3, 4'd0, 16'd5);
        rom[2] = enc_i(OP_LD,  4'd4, 4'd0, 16'd5);
        rom[3] = enc_r(OP_OUT, 4'd4, 4'd0, 4'd0);
        rom[4] = {OP_HALT, 24'h0};
        sb.push_back(32'h0000_1234);
        release_reset();
        exp = sb.pop_front();
        wait_change(30, to, d);
        n_chk++;
        if (to || port_out !== exp) begin
            n_err++;
            $display("FAIL mem_roundtrip: got %h expected %h", port_out, exp);
        end
        n_chk++;
        if (d != 9) begin
            n_err++;
            $display("FAIL mem_ld_timing: got cycle %0d expected 9", d);
        end
    endtask

    task automatic test_alu();
        logic [31:0] a, b, t, exp;
        bit to;
        int d;
        a = 32'h0000_00F0;
        b = 32'hFFFF_FFFC;
        t = a + 32'hFFFF_8000;
        hold_reset();
        clear_rom();
        rom[0]  = enc_i(OP_LDI, 4'd1, 4'd0, 16'h00F0);
        rom[1]  = enc_i(OP_LDI, 4'd2, 4'd0, 16'hFFFC);
        rom[2]  = enc_i(OP_LDI, 4'd4, 4'd0, 16'd4);
        rom[3]  = enc_r(OP_ADD, 4'd3, 4'd1, 4'd2);
        rom[5]  = enc_r(OP_SUB, 4'd3, 4'd1, 4'd2);
        rom[7]  = enc_r(OP_AND, 4'd3, 4'd1, 4'd2);
        rom[9]  = enc_r(OP_OR,  4'd3, 4'd1, 4'd2);
        rom[11] = enc_r(OP_XOR, 4'd3, 4'd1, 4'd2);
        rom[13] = enc_r(OP_SHL, 4'd3, 4'd1, 4'd4);
        rom[15] = enc_r(OP_SHR, 4'd3, 4'd2, 4'd4);
        rom[17] = enc_i(OP_ADDI, 4'd3, 4'd1, 16'h8000);
        rom[19] = enc_i(OP_LDIH, 4'd3, 4'd0, 16'hABCD);
        for (int i = 4; i <= 20; i += 2) rom[i] = enc_r(OP_OUT, 4'd3, 4'd0, 4'd0);
        rom[21] = enc_i(OP_LDI, 4'd3, 4'd0, 16'd7);
        rom[22] = enc_r(OP_X13, 4'd3, 4'd1, 4'd1);
        rom[23] = enc_r(OP_OUT, 4'd3, 4'd0, 4'd0);
        rom[24] = {OP_HALT, 24'h0};
        sb.push_back(a + b);
        sb.push_back(a - b);
        sb.push_back(a & b);
        sb.push_back(a | b);
        sb.push_back(a ^ b);
        sb.push_back(a << 4);
        sb.push_back(b >> 4);
        sb.push_back(t);
        sb.push_back({16'hABCD, t[15:0]});
`ifdef SC1_MUL_EN
        sb.push_back(a * a);
`else
        sb.push_back(32'd7);
`endif
        release_reset();
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            wait_change(20, to, d);
            n_chk++;
            if (to || port_out !== exp) begin
                n_err++;
                $display("FAIL alu_value: got %h expected %h at cycle %0d", port_out, exp, d);
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] exp;
        bit to;
        int d;
        int want [3];
        want[0] = 8;
        want[1] = 16;
        want[2] = 22;
        hold_reset();
        clear_rom();
        rom[0]   = enc_i(OP_LDI, 4'd1, 4'd0, 16'd0);
        rom[1]   = enc_i(OP_BEZ, 4'd1, 4'd0, 16'd10);
        rom[2]   = enc_i(OP_LDI, 4'd6, 4'd0, 16'h0BAD);
        rom[3]   = enc_r(OP_OUT, 4'd6, 4'd0, 4'd0);
        rom[10]  = enc_i(OP_LDI, 4'd6, 4'd0, 16'h000A);
        rom[11]  = enc_r(OP_OUT, 4'd6, 4'd0, 4'd0);
        rom[12]  = enc_i(OP_LDI, 4'd1, 4'd0, 16'd1);
        rom[13]  = enc_i(OP_BEZ, 4'd1, 4'd0, 16'd20);
        rom[14]  = enc_i(OP_LDI, 4'd6, 4'd0, 16'h000E);
        rom[15]  = enc_r(OP_OUT, 4'd6, 4'd0, 4'd0);
        rom[16]  = enc_i(OP_LDI, 4'd7, 4'd0, 16'h0055);
        rom[17]  = enc_i(OP_JMP, 4'd0, 4'd0, 16'd255);
        rom[20]  = enc_i(OP_LDI, 4'd6, 4'd0, 16'h0BAD);
        rom[21]  = enc_r(OP_OUT, 4'd6, 4'd0, 4'd0);
        rom[255] = enc_r(OP_OUT, 4'd7, 4'd0, 4'd0);
        sb.push_back(32'h0000_000A);
        sb.push_back(32'h0000_000E);
        sb.push_back(32'h0000_0055);
        release_reset();
        repeat (4) @(negedge clk);
        n_chk++;
        if (rom_addr !== 8'd10) begin
            n_err++;
            $display("FAIL bez_taken_pc: got %h expected 0a", rom_addr);
        end
        for (int i = 0; i < 3; i++) begin
            exp = sb.pop_front();
            wait_change(30, to, d);
            n_chk++;
            if (to || port_out !== exp || d != want[i]) begin
                n_err++;
                $display("FAIL branch_out: got %h at cycle %0d expected %h at cycle %0d",
                         port_out, d, exp, want[i]);
            end
        end
        n_chk++;
        if (rom_addr !== 8'd0) begin
            n_err++;
            $display("FAIL pc_wrap: got %h expected 00", rom_addr);
        end
    endtask

    task automatic test_in_halt();
        logic [31:0] exp;
        bit to;
        int d;
        hold_reset();
        clear_rom();
        rom[0] = enc_r(OP_IN,  4'd5, 4'd0, 4'd0);
        rom[1] = enc_r(OP_OUT, 4'd5, 4'd0, 4'd0);
        rom[2] = {OP_HALT, 24'h0};
        rom[3] = enc_r(OP_OUT, 4'd0, 4'd0, 4'd0);
        port_in = 32'hDEAD_BEEF;
        sb.push_back(32'hDEAD_BEEF);
        release_reset();
        exp = sb.pop_front();
        wait_change(20, to, d);
        n_chk++;
        if (to || port_out !== exp || d != 4) begin
            n_err++;
            $display("FAIL in_out: got %h at cycle %0d expected %h at cycle 4", port_out, d, exp);
        end
        port_in = 32'h1357_9BDF;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_chk++;
            if (rom_addr !== 8'd2 || port_out !== exp) begin
                n_err++;
                $display("FAIL halt_hold: got addr %h out %h expected addr 02 out %h",
                         rom_addr, port_out, exp);
            end
        end
    endtask

    task automatic test_reset_mid_st();
        logic [31:0] exp;
        bit to;
        int d;
        hold_reset();
        clear_rom();
        rom[0] = enc_i(OP_LDI, 4'd3, 4'd0, 16'h0055);
        rom[1] = enc_i(OP_ST,  4'd3, 4'd0, 16'd7);
        rom[2] = enc_i(OP_LDI, 4'd3, 4'd0, 16'h0099);
        rom[3] = enc_i(OP_ST,  4'd3, 4'd0, 16'd7);
        release_reset();
        repeat (7) @(negedge clk);
        n_chk++;
        if (rom_addr !== 8'd3) begin
            n_err++;
            $display("FAIL mid_st_setup: got %h expected 03", rom_addr);
        end
        reset = 1'b0;
        @(negedge clk);
        n_chk++;
        if (rom_addr !== 8'd0) begin
            n_err++;
            $display("FAIL mid_st_pc: got %h expected 00", rom_addr);
        end
        clear_rom();
        rom[0] = enc_i(OP_LD,  4'd4, 4'd0, 16'd7);
        rom[1] = enc_r(OP_OUT, 4'd4, 4'd0, 4'd0);
        rom[2] = {OP_HALT, 24'h0};
        sb.push_back(32'h0000_0055);
        release_reset();
        exp = sb.pop_front();
        wait_change(20, to, d);
        n_chk++;
        if (to || port_out !== exp || d != 5) begin
            n_err++;
            $display("FAIL mid_st_ram: got %h at cycle %0d expected %h at cycle 5",
                     port_out, d, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_counter();
        test_mem();
        test_alu();
        test_branch();
        test_in_halt();
        test_reset_mid_st();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sc1_cpu_core.md
Name: sc1_cpu_core

Overview:
- Small multi-cycle 32-bit-instruction processor.
- Fetches instructions from an external synchronous program ROM, executes on a 16-entry register file, and owns an internal data RAM.
- Talks to the outside world through one input and one output port.
- Top-level compute element of the sc1 design. The bench watches port_out as a program-driven counter.

Parameters:
- WIDTH_D, 32, data RAM word width.
- WIDTH_REG, 32, register, port and ALU width (at least 16).
- DEPTH_I, 8, program address width (2^DEPTH_I instructions).
- DEPTH_D, 8, data RAM address width (2^DEPTH_D words).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled at rising clk).
- rom_addr  output  DEPTH_I  program address; equals pc (combinational).
- rom_data  input  32  instruction word; ROM registers addr, so data is valid one cycle after addr.
- port_in  input  WIDTH_REG  general input port, read by IN.
- port_out  output  WIDTH_REG  registered output port, written by OUT.

Behaviour:
- Reset (reset==0 at clk edge):
  - pc=0, state=FETCH, all 16 registers=0, port_out=0, halted=0.
  - Data RAM contents are unchanged.
  - Reset mid-instruction aborts it; no RAM or register write occurs in that cycle.
- States:
  - FETCH (1 cycle): ROM latches pc.
  - EXEC (1 cycle): decode rom_data, execute, update pc. Next state is FETCH, or MEM for LD.
  - MEM (1 cycle): write the RAM read data to rd.
  - Instruction cost: 2 cycles per instruction; LD costs 3.
- pc update: pc advances by 1 (mod 2^DEPTH_I) unless a taken jump/branch loads imm[DEPTH_I-1:0].
- Instruction fields:
  - op=[31:24], rd=[23:20], ra=[19:16], rb=[15:12].
  - imm=[15:0]; overlaps rb, used only by immediate forms.
  - sext = sign-extend imm to WIDTH_REG.
- Opcodes:
  - 0x00 NOP.
  - 0x01 LDI: rd=sext(imm).
  - 0x02 LDIH: rd=(imm<<16) | rd[15:0].
  - 0x03 ADD: rd=ra+rb.
  - 0x04 SUB: rd=ra-rb.
  - 0x05 AND, 0x06 OR, 0x07 XOR: bitwise on ra, rb.
  - 0x08 SHL: rd=ra<<rb[4:0].
  - 0x09 SHR: rd=ra>>rb[4:0], logical.
  - 0x0A ADDI: rd=ra+sext(imm).
  - 0x0B LD: rd=RAM[(ra+sext(imm)) mod 2^DEPTH_D], zero-extended or truncated to WIDTH_REG.
  - 0x0C ST: RAM[same address]=rd, truncated or zero-extended to WIDTH_D.
  - 0x0D IN: rd=port_in, sampled in EXEC.
  - 0x0E OUT: port_out<=rd.
  - 0x0F JMP: pc=imm.
  - 0x10 BEZ: if rd==0 then pc=imm.
  - 0x11 BNZ: if rd!=0 then pc=imm.
  - 0x12 HALT: pc frozen, state stays FETCH↔EXEC on the same word, no side effects. Only reset exits HALT.
  - Other opcodes execute as NOP.
- Arithmetic rules:
  - All arithmetic is modulo 2^WIDTH_REG; no flags.
  - Register reads see writes from earlier instructions; no hazards exist (multi-cycle).
- Memories:
  - Data RAM: synchronous read and write, one port, no reset.
  - Register file: 16 x WIDTH_REG; all registers are general purpose, r0 included.

Optional Feature:
- SC1_MUL_EN defined: opcode 0x13 MUL, rd = low WIDTH_REG bits of ra*rb (unsigned), same 2-cycle timing.
- SC1_MUL_EN undefined: 0x13 is a NOP and no multiplier is synthesized.

Test Plan:
- Reset:
  - Stimulus: hold reset=0 for 2 cycles, then release.
  - Required: rom_addr=0, port_out=0 throughout reset; first FETCH of address 0 happens on the cycle after release.
- Counter program:
  - Stimulus: LDI r1,0; LDI r2,1; ADD r1,r1,r2; OUT r1; JMP 2.
  - Required: port_out steps 1,2,3,… with exactly 6 cycles between increments.
- Memory round trip:
  - Stimulus: LDI r3,0x1234; ST r3,[r0+5]; LD r4,[r0+5]; OUT r4.
  - Required: port_out=0x1234; LD costs 3 cycles.
- Branches and wrap:
  - Stimulus: BEZ on r=0 to address 10.
  - Required: pc=10 next FETCH. Same BEZ on r=1 falls through to pc+1. Code at 2^DEPTH_I-1 wraps to pc=0.
- IN/HALT:
  - Stimulus: port_in=0xDEADBEEF; IN r5; OUT r5; HALT; then a further OUT.
  - Required: port_out=0xDEADBEEF, and rom_addr is constant at the HALT address; the later OUT never executes.
- Reset mid-ST:
  - Stimulus: assert reset during the ST EXEC cycle.
  - Required: target RAM word is unchanged, pc=0.
